// File: rtl/snoop_bus_arbiter.sv
// -----------------------------------------------------------------------------
// snoop_bus_arbiter
//
// Round-robin arbiter that sits in front of the shared snoop bus / L2 path.
// One L1 core at a time is granted. While the core holds the grant, its
// address, write data and operation are latched and held stable on the bus.
// The grant ends when the coherence FSM pulses bus_done. If bus_done never
// arrives, a watchdog forces the release instead.
//
// Ports
//   clk          in   rising-edge system clock
//   rst          in   asynchronous, active-low reset
//   req_rd       in   [NUM_CORES]            per-core read request (level)
//   req_wr       in   [NUM_CORES]            per-core write request (level)
//   req_addr     in   [NUM_CORES*ADDR_WIDTH] core i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_data     in   [NUM_CORES*DATA_WIDTH] core i at [i*DATA_WIDTH +: DATA_WIDTH]
//   bus_done     in   1-cycle pulse: current transaction complete
//   gnt          out  [NUM_CORES] one-hot grant (registered)
//   bus_valid    out  bus carries a live transaction
//   bus_rd       out  live transaction is a read
//   bus_wr       out  live transaction is a write
//   bus_addr     out  [ADDR_WIDTH] latched address of the granted core
//   bus_data     out  [DATA_WIDTH] latched write data of the granted core
//   bus_owner    out  [$clog2(NUM_CORES)] index of the granted core
//   timeout_err  out  1-cycle pulse when the watchdog forces a release
// -----------------------------------------------------------------------------
module snoop_bus_arbiter #(
    parameter int NUM_CORES  = 4,
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CORES-1:0]            req_rd,
    input  logic [NUM_CORES-1:0]            req_wr,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_CORES*DATA_WIDTH-1:0] req_data,
    input  logic                            bus_done,
    output logic [NUM_CORES-1:0]            gnt,
    output logic                            bus_valid,
    output logic                            bus_rd,
    output logic                            bus_wr,
    output logic [ADDR_WIDTH-1:0]           bus_addr,
    output logic [DATA_WIDTH-1:0]           bus_data,
    output logic [$clog2(NUM_CORES)-1:0]    bus_owner,
    output logic                            timeout_err
);

    localparam int IDX_W = $clog2(NUM_CORES);
    localparam int TMR_W = $clog2(TIMEOUT) + 1;

    localparam logic [IDX_W-1:0]     PTR_RESET  = IDX_W'(NUM_CORES - 1);
    localparam logic [TMR_W-1:0]     TIMER_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [NUM_CORES-1:0] GNT_ONE    = {{(NUM_CORES-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                  state_r;
    logic [IDX_W-1:0]        ptr_r;
    logic [TMR_W-1:0]        timer_r;

    logic [NUM_CORES-1:0]    req_any_s;
    logic                    win_found_s;
    logic [IDX_W-1:0]        win_idx_s;
    logic                    win_wr_s;
    logic [ADDR_WIDTH-1:0]   win_addr_s;
    logic [DATA_WIDTH-1:0]   win_data_s;
    int                      cand_s;

    assign req_any_s = req_rd | req_wr;

    // Round-robin search: first requester after the last owner (ptr+1, ptr+2, ...).
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = 0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            cand_s = (int'(ptr_r) + k) % NUM_CORES;
            if (!win_found_s && req_any_s[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = IDX_W'(cand_s);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Winner's payload. A core raising both read and write is treated as a write.
    always_comb begin
        win_wr_s   = req_wr[win_idx_s];
        win_addr_s = req_addr[win_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
        win_data_s = req_data[win_idx_s*DATA_WIDTH +: DATA_WIDTH];
    end

    // Arbitration FSM with registered grant/bus outputs and the BUSY watchdog.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            ptr_r       <= PTR_RESET;
            timer_r     <= '0;
            gnt         <= '0;
            bus_valid   <= 1'b0;
            bus_rd      <= 1'b0;
            bus_wr      <= 1'b0;
            bus_addr    <= '0;
            bus_data    <= '0;
            bus_owner   <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (win_found_s) begin
                        gnt       <= GNT_ONE << win_idx_s;
                        bus_valid <= 1'b1;
                        bus_wr    <= win_wr_s;
                        bus_rd    <= ~win_wr_s;
                        bus_addr  <= win_addr_s;
                        bus_data  <= win_data_s;
                        bus_owner <= win_idx_s;
                        timer_r   <= '0;
                        state_r   <= ST_BUSY;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    // bus_done wins over the watchdog on the same edge: no error then.
                    if (bus_done) begin
                        gnt       <= '0;
                        bus_valid <= 1'b0;
                        bus_rd    <= 1'b0;
                        bus_wr    <= 1'b0;
                        ptr_r     <= bus_owner;
                        state_r   <= ST_RELEASE;
                    end else if (timer_r == TIMER_LAST) begin
                        gnt         <= '0;
                        bus_valid   <= 1'b0;
                        bus_rd      <= 1'b0;
                        bus_wr      <= 1'b0;
                        ptr_r       <= bus_owner;
                        timeout_err <= 1'b1;
                        state_r     <= ST_RELEASE;
                    end else begin
                        timer_r     <= timer_r + TMR_W'(1);
                    end
                end
                ST_RELEASE: begin
                    // Turnaround cycle; bus_done is ignored here.
                    state_r <= ST_IDLE;
                end
                default: begin
                    gnt       <= '0;
                    bus_valid <= 1'b0;
                    bus_rd    <= 1'b0;
                    bus_wr    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_snoop_bus_arbiter
//
// Directed bench for snoop_bus_arbiter. A table of per-cycle vectors covers
// the basic flows: fairness, a single read, and read+write on the same core.
// Hand-written sequences cover the watchdog timeout, bus_done arriving on the
// last BUSY cycle, bus stability while BUSY, and asynchronous reset.
// Outputs are packed as {gnt, valid, rd, wr, addr, data, owner, timeout_err}.
// -----------------------------------------------------------------------------
module tb_snoop_bus_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_rd;
    logic [3:0]  req_wr;
    logic [11:0] req_addr;
    logic [31:0] req_data;
    logic        bus_done;
    logic [3:0]  gnt;
    logic        bus_valid;
    logic        bus_rd;
    logic        bus_wr;
    logic [2:0]  bus_addr;
    logic [7:0]  bus_data;
    logic [1:0]  bus_owner;
    logic        timeout_err;

    snoop_bus_arbiter #(
        .NUM_CORES (4),
        .ADDR_WIDTH(3),
        .DATA_WIDTH(8),
        .TIMEOUT   (15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_rd     (req_rd),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .bus_done   (bus_done),
        .gnt        (gnt),
        .bus_valid  (bus_valid),
        .bus_rd     (bus_rd),
        .bus_wr     (bus_wr),
        .bus_addr   (bus_addr),
        .bus_data   (bus_data),
        .bus_owner  (bus_owner),
        .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  rd;
        logic [3:0]  wr;
        logic        done;
        logic [20:0] exp;
    } vec_t;

    vec_t        vecs[$];
    int          applied;
    int          miscompares;
    logic [11:0] addr_all;
    logic [31:0] data_all;

    // Core addresses: c0=1, c1=2, c2=5, c3=4. Core data: c0=11, c1=A5, c2=22, c3=33.
    localparam logic [11:0] ADDR_A = {3'h4, 3'h5, 3'h2, 3'h1};
    localparam logic [31:0] DATA_D = {8'h33, 8'h22, 8'hA5, 8'h11};

    function automatic logic [20:0] pk(input logic [3:0] g, input logic v, input logic r,
                                       input logic w, input logic [2:0] a, input logic [7:0] d,
                                       input logic [1:0] o, input logic t);
        return {g, v, r, w, a, d, o, t};
    endfunction

    task automatic add(input logic [3:0] rd, input logic [3:0] wr, input logic done,
                       input logic [20:0] exp);
        vec_t v;
        v.rd = rd;
        v.wr = wr;
        v.done = done;
        v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One comparison: full packed output plus the one-hot / valid / rd-wr invariants.
    task automatic check(input string name, input logic [20:0] exp);
        logic [20:0] act;
        logic        inv_ok;
        act    = {gnt, bus_valid, bus_rd, bus_wr, bus_addr, bus_data, bus_owner, timeout_err};
        inv_ok = $onehot0(gnt) && ((gnt != 4'b0000) == bus_valid) && !(bus_rd && bus_wr);
        applied++;
        if (act !== exp || !inv_ok) begin
            miscompares++;
            $display("FAIL %s: got gnt=%b v=%b rd=%b wr=%b addr=%h data=%h own=%0d terr=%b, required %h (got %h, invariants_ok=%b)",
                     name, gnt, bus_valid, bus_rd, bus_wr, bus_addr, bus_data, bus_owner,
                     timeout_err, exp, act, inv_ok);
        end
    endtask

    initial begin
        logic [20:0] e;
        int          c;
        applied     = 0;
        miscompares = 0;
        addr_all    = ADDR_A;
        data_all    = DATA_D;

        // Fairness: all cores write, bus_done on the first BUSY cycle -> order 0,1,2,3,0,
        // one grant every 3 cycles. bus_done in RELEASE (core 1 round) is ignored.
        for (int i = 0; i < 5; i++) begin
            c = i % 4;
            add(4'b0000, 4'b1111, 1'b0,
                pk(4'b0001 << c, 1'b1, 1'b0, 1'b1, addr_all[c*3 +: 3], data_all[c*8 +: 8], 2'(c), 1'b0));
            add(4'b0000, 4'b1111, 1'b1,
                pk(4'b0000, 1'b0, 1'b0, 1'b0, addr_all[c*3 +: 3], data_all[c*8 +: 8], 2'(c), 1'b0));
            add(4'b0000, 4'b1111, (c == 1),
                pk(4'b0000, 1'b0, 1'b0, 1'b0, addr_all[c*3 +: 3], data_all[c*8 +: 8], 2'(c), 1'b0));
        end
        // Single read by core 2 (ptr=0), bus_done 2 cycles after the grant; request drops early.
        add(4'b0100, 4'b0000, 1'b0, pk(4'b0100, 1'b1, 1'b1, 1'b0, 3'h5, 8'h22, 2'd2, 1'b0));
        add(4'b0100, 4'b0000, 1'b0, pk(4'b0100, 1'b1, 1'b1, 1'b0, 3'h5, 8'h22, 2'd2, 1'b0));
        add(4'b0000, 4'b0000, 1'b1, pk(4'b0000, 1'b0, 1'b0, 1'b0, 3'h5, 8'h22, 2'd2, 1'b0));
        add(4'b0000, 4'b0000, 1'b0, pk(4'b0000, 1'b0, 1'b0, 1'b0, 3'h5, 8'h22, 2'd2, 1'b0));
        // bus_done in IDLE with no request: nothing happens.
        add(4'b0000, 4'b0000, 1'b1, pk(4'b0000, 1'b0, 1'b0, 1'b0, 3'h5, 8'h22, 2'd2, 1'b0));
        // Core 1 raises read and write together -> write, data A5 (ptr=2 searches 3,0,1).
        add(4'b0010, 4'b0010, 1'b0, pk(4'b0010, 1'b1, 1'b0, 1'b1, 3'h2, 8'hA5, 2'd1, 1'b0));
        add(4'b0000, 4'b0000, 1'b0, pk(4'b0010, 1'b1, 1'b0, 1'b1, 3'h2, 8'hA5, 2'd1, 1'b0));
        add(4'b0000, 4'b0000, 1'b1, pk(4'b0000, 1'b0, 1'b0, 1'b0, 3'h2, 8'hA5, 2'd1, 1'b0));
        add(4'b0000, 4'b0000, 1'b0, pk(4'b0000, 1'b0, 1'b0, 1'b0, 3'h2, 8'hA5, 2'd1, 1'b0));

        // Reset held with every request high: nothing may be granted.
        rst      = 1'b0;
        req_rd   = 4'b1111;
        req_wr   = 4'b1111;
        req_addr = ADDR_A;
        req_data = DATA_D;
        bus_done = 1'b0;
        step();
        step();
        check("reset_all_req_high", 21'd0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            req_rd   = vecs[i].rd;
            req_wr   = vecs[i].wr;
            bus_done = vecs[i].done;
            step();
            check($sformatf("vec[%0d]", i), vecs[i].exp);
        end

        // Timeout: core 3 granted (ptr=1), bus_done never comes -> 15 BUSY cycles.
        bus_done = 1'b0;
        req_rd   = 4'b0000;
        req_wr   = 4'b1000;
        step();
        e = pk(4'b1000, 1'b1, 1'b0, 1'b1, 3'h4, 8'h33, 2'd3, 1'b0);
        check("timeout_grant_core3", e);
        req_wr = 4'b0000;
        for (int k = 1; k <= 14; k++) begin
            step();
            check($sformatf("timeout_hold_%0d", k), e);
        end
        step();
        check("timeout_release", pk(4'b0000, 1'b0, 1'b0, 1'b0, 3'h4, 8'h33, 2'd3, 1'b1));
        req_rd = 4'b1111;
        step();
        check("timeout_pulse_end", pk(4'b0000, 1'b0, 1'b0, 1'b0, 3'h4, 8'h33, 2'd3, 1'b0));
        step();
        e = pk(4'b0001, 1'b1, 1'b1, 1'b0, 3'h1, 8'h11, 2'd0, 1'b0);
        check("after_timeout_core0", e);

        // bus_done on the 15th BUSY cycle: normal release, no error.
        req_rd = 4'b0000;
        for (int k = 1; k <= 14; k++) begin
            step();
            check($sformatf("late_done_hold_%0d", k), e);
        end
        bus_done = 1'b1;
        step();
        check("done_on_15th", pk(4'b0000, 1'b0, 1'b0, 1'b0, 3'h1, 8'h11, 2'd0, 1'b0));
        bus_done = 1'b0;
        step();
        check("no_late_err", pk(4'b0000, 1'b0, 1'b0, 1'b0, 3'h1, 8'h11, 2'd0, 1'b0));

        // Stability: core 2 granted (ptr=0), then its address/data change while BUSY.
        req_wr = 4'b0100;
        step();
        e = pk(4'b0100, 1'b1, 1'b0, 1'b1, 3'h5, 8'h22, 2'd2, 1'b0);
        check("stable_grant_core2", e);
        req_wr   = 4'b0000;
        req_addr = 12'hFFF;
        req_data = 32'hFFFF_FFFF;
        step();
        check("stable_addr_1", e);
        step();
        check("stable_addr_2", e);

        // Asynchronous reset mid-BUSY, away from any clock edge.
        #3;
        rst = 1'b0;
        #1;
        check("async_reset", 21'd0);
        step();
        check("reset_held", 21'd0);
        req_addr = ADDR_A;
        req_data = DATA_D;
        bus_done = 1'b1;
        rst      = 1'b1;
        step();
        check("no_valid_after_reset", 21'd0);
        bus_done = 1'b0;
        req_rd   = 4'b0011;
        step();
        check("ptr_reset_core0", pk(4'b0001, 1'b1, 1'b1, 1'b0, 3'h1, 8'h11, 2'd0, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
